// File: rtl/bp_io_wormhole_deserializer_pkg.sv
// Shared types for the I/O command NoC receive endpoint: header layout,
// deserializer FSM states and the header-width macro.
`ifndef BP_IO_HDR_WIDTH
`define BP_IO_HDR_WIDTH(cord_w, len_w) ((cord_w) + (len_w))
`endif

package bp_io_wormhole_deserializer_pkg;

  localparam int unsigned lp_flit_width = 64;
  localparam int unsigned lp_cord_width = 8;
  localparam int unsigned lp_len_width  = 4;
  localparam int unsigned lp_max_len    = 7;

  typedef enum logic [1:0] {
    e_idle,
    e_body,
    e_drain,
    e_full
  } state_e;

  // Header flit: cord in the LSBs, len above it, the rest is payload.
  typedef struct packed {
    logic [lp_flit_width-`BP_IO_HDR_WIDTH(lp_cord_width, lp_len_width)-1:0] payload;
    logic [lp_len_width-1:0]  len;
    logic [lp_cord_width-1:0] cord;
  } io_hdr_s;

endpackage

// File: rtl/bp_io_flit_buffer.sv
// Slot-addressed flit store. A header capture writes slot 0 and clears all
// other slots so unused slots of a short packet read back as zero.
module bp_io_flit_buffer #(
  parameter int flit_width_p = 64,
  parameter int len_width_p  = 4,
  parameter int slots_p      = 8
) (
  input  logic                            clk_i,
  input  logic                            reset_n_i,
  input  logic                            i_we,
  input  logic                            i_clr,
  input  logic [len_width_p-1:0]          i_slot,
  input  logic [flit_width_p-1:0]         i_data,
  output logic [slots_p*flit_width_p-1:0] o_pkt
);

  logic [flit_width_p-1:0] r_slot [slots_p];

  for (genvar gi = 0; gi < slots_p; gi++) begin : g_slot
    always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
        r_slot[gi] <= '0;
      end else if (i_clr) begin
        r_slot[gi] <= (gi == 0) ? i_data : '0;
      end else if (i_we && (i_slot == len_width_p'(gi))) begin
        r_slot[gi] <= i_data;
      end
    end
    assign o_pkt[gi*flit_width_p +: flit_width_p] = r_slot[gi];
  end

endmodule

// File: rtl/bp_io_wormhole_deserializer.sv
// Reassembles wormhole packets (header + len body flits) into one wide
// buffer and hands them to a valid/ready consumer; oversize packets are drained.
module bp_io_wormhole_deserializer
  import bp_io_wormhole_deserializer_pkg::*;
#(
  parameter int flit_width_p = lp_flit_width,
  parameter int cord_width_p = lp_cord_width,
  parameter int len_width_p  = lp_len_width,
  parameter int max_len_p    = lp_max_len
) (
  input  logic                                clk_i,
  input  logic                                reset_n_i,
  input  logic [flit_width_p+1:0]             link_i,
  output logic [flit_width_p+1:0]             link_o,
  output logic [(max_len_p+1)*flit_width_p-1:0] pkt_o,
  output logic [len_width_p-1:0]              pkt_len_o,
  output logic                                pkt_v_o,
  input  logic                                pkt_ready_and_i,
  output logic                                err_o
);

  localparam int lp_hdr_width = `BP_IO_HDR_WIDTH(cord_width_p, len_width_p);
  localparam logic [len_width_p-1:0] lp_max_len_c = len_width_p'(max_len_p);

  state_e                  r_state, w_state_next;
  logic [len_width_p-1:0]  r_cnt, r_len;
  logic                    w_link_v, w_ready, w_xfer, w_last, w_fits;
  logic                    w_we, w_clr;
  logic [flit_width_p-1:0] w_flit;
  logic [len_width_p-1:0]  w_hdr_len;

  assign w_link_v  = link_i[flit_width_p+1];
  assign w_flit    = link_i[flit_width_p:1];
  assign w_hdr_len = w_flit[lp_hdr_width-1:cord_width_p];
  assign w_fits    = (w_hdr_len <= lp_max_len_c);
  assign w_xfer    = w_link_v & w_ready;
  assign w_last    = (r_cnt == r_len);

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_state <= e_idle;
      r_cnt   <= '0;
      r_len   <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == e_idle && w_xfer) begin
        r_cnt <= len_width_p'(1);
        r_len <= w_hdr_len;
      end else if ((r_state == e_body || r_state == e_drain) && w_xfer) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      e_idle: begin
        if (w_xfer) begin
          if (w_hdr_len == '0) w_state_next = e_full;
          else if (w_fits)     w_state_next = e_body;
          else                 w_state_next = e_drain;
        end
      end
      e_body:  if (w_xfer && w_last) w_state_next = e_full;
      e_drain: if (w_xfer && w_last) w_state_next = e_idle;
      e_full:  if (pkt_ready_and_i)  w_state_next = e_idle;
      default: w_state_next = e_idle;
    endcase
  end

  // Outputs are forced low while reset is held, even before the first edge.
  always_comb begin
    w_ready = 1'b0;
    pkt_v_o = 1'b0;
    err_o   = 1'b0;
    w_we    = 1'b0;
    w_clr   = 1'b0;
    if (reset_n_i) begin
      case (r_state)
        e_idle: begin
          w_ready = 1'b1;
          w_clr   = w_link_v & w_fits;
        end
        e_body: begin
          w_ready = 1'b1;
          w_we    = w_link_v;
        end
        e_drain: begin
          w_ready = 1'b1;
          err_o   = w_link_v & w_last;
        end
        e_full:  pkt_v_o = 1'b1;
        default: ;
      endcase
    end
  end

  assign link_o    = {1'b0, {flit_width_p{1'b0}}, w_ready};
  assign pkt_len_o = r_len;

  bp_io_flit_buffer #(
    .flit_width_p(flit_width_p),
    .len_width_p (len_width_p),
    .slots_p     (max_len_p+1)
  ) u_buf (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .i_we     (w_we),
    .i_clr    (w_clr),
    .i_slot   (r_cnt),
    .i_data   (w_flit),
    .o_pkt    (pkt_o)
  );

endmodule

// File: tb/tb_bp_io_wormhole_deserializer.sv
// Self-checking bench: directed cases plus a random packet stream against
// a queue-based scoreboard of expected packets.
module tb_bp_io_wormhole_deserializer;
  import bp_io_wormhole_deserializer_pkg::*;

  localparam int FW = 64;
  localparam int LW = 4;
  localparam int ML = 7;
  localparam int PW = (ML+1)*FW;

  logic          clk = 1'b0;
  logic          reset_n_i = 1'b0;
  logic [FW+1:0] link_i = '0;
  logic [FW+1:0] link_o;
  logic [PW-1:0] pkt_o;
  logic [LW-1:0] pkt_len_o;
  logic          pkt_v_o;
  logic          pkt_ready_and_i = 1'b0;
  logic          err_o;

  always #5 clk = ~clk;

  bp_io_wormhole_deserializer dut (
    .clk_i          (clk),
    .reset_n_i      (reset_n_i),
    .link_i         (link_i),
    .link_o         (link_o),
    .pkt_o          (pkt_o),
    .pkt_len_o      (pkt_len_o),
    .pkt_v_o        (pkt_v_o),
    .pkt_ready_and_i(pkt_ready_and_i),
    .err_o          (err_o)
  );

  typedef struct {
    logic [PW-1:0] pkt;
    logic [LW-1:0] len;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_pass = 0;
  int   cons_mode = 0;  // 0 always ready, 1 never ready, 2 random
  int   err_cnt = 0;
  int   v_cnt = 0;
  int   n_deliv = 0;

  task automatic chk(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Consumer and scoreboard: a packet pops when valid and ready meet.
  initial forever begin
    @(negedge clk);
    pkt_ready_and_i = (cons_mode == 0) ? 1'b1 :
                      (cons_mode == 1) ? 1'b0 : ($urandom_range(0, 3) != 0);
    #1;
    if (err_o) err_cnt++;
    if (pkt_v_o) v_cnt++;
    if (pkt_v_o && pkt_ready_and_i) begin
      n_deliv++;
      if (sb.size() == 0) chk("spurious_pkt", PW'(1), PW'(0));
      else begin
        mon_e = sb.pop_front();
        chk("pkt_data", pkt_o, mon_e.pkt);
        chk("pkt_len", PW'(pkt_len_o), PW'(mon_e.len));
      end
    end
  end

  task automatic send_flit(input logic [FW-1:0] d, output int waits);
    @(negedge clk);
    link_i = {1'b1, d, 1'b0};
    waits = 0;
    while (!link_o[0] && waits < 200) begin
      @(negedge clk);
      waits++;
    end
    if (!link_o[0]) chk("link_timeout", PW'(0), PW'(1));
    @(posedge clk);
    #1;
    link_i = '0;
  endtask

  function automatic logic [FW-1:0] mk_hdr(input int len);
    io_hdr_s h;
    h.cord    = 8'($urandom());
    h.len     = 4'(len);
    h.payload = 52'({$urandom(), $urandom()});
    return h;
  endfunction

  task automatic send_pkt(input logic [FW-1:0] hdr, input int bubble_pct, output int hw);
    exp_t e;
    int   w;
    int   len;
    int   b;
    logic [FW-1:0] d;
    len   = int'(hdr[11:8]);
    e.pkt = '0;
    e.pkt[FW-1:0] = hdr;
    e.len = hdr[11:8];
    send_flit(hdr, hw);
    for (int k = 1; k <= len; k++) begin
      b = 0;
      while ($urandom_range(0, 99) < bubble_pct && b < 4) begin
        @(negedge clk);
        b++;
      end
      d = {$urandom(), $urandom()};
      if (k <= ML) e.pkt[k*FW +: FW] = d;
      send_flit(d, w);
    end
    if (len <= ML) sb.push_back(e);
  endtask

  task automatic wait_drain();
    int t = 0;
    while (sb.size() != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    #2;
    chk("sb_empty", PW'(sb.size()), PW'(0));
  endtask

  initial begin
    int            w;
    int            eb;
    int            vb;
    int            db;
    logic [FW-1:0] hdr;
    logic [PW-1:0] exp_pkt;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_pkt_v", PW'(pkt_v_o), PW'(0));
    chk("rst_err", PW'(err_o), PW'(0));
    chk("rst_link_o", PW'(link_o), PW'(0));
    @(negedge clk);
    reset_n_i = 1'b1;
    #1;
    chk("rel_ready", PW'(link_o[0]), PW'(1));

    // 1: single-flit packet, held until inspected
    cons_mode = 1;
    hdr = 64'h0000_0000_0003_0005;
    chk("t1_pre_v", PW'(pkt_v_o), PW'(0));
    send_pkt(hdr, 0, w);
    chk("t1_v", PW'(pkt_v_o), PW'(1));
    chk("t1_len", PW'(pkt_len_o), PW'(0));
    chk("t1_pkt", pkt_o, PW'(hdr));
    chk("t1_ready_full", PW'(link_o[0]), PW'(0));
    @(posedge clk);
    #2;
    cons_mode = 0;
    wait_drain();

    // 2: len=3 with a two-cycle bubble after the first body flit
    hdr = {52'h0_1234_5678_9ABC, 4'd3, 8'h11};
    exp_pkt = '0;
    exp_pkt[FW-1:0]       = hdr;
    exp_pkt[1*FW +: FW]   = 64'hA;
    exp_pkt[2*FW +: FW]   = 64'hB;
    exp_pkt[3*FW +: FW]   = 64'hC;
    send_flit(hdr, w);
    send_flit(64'hA, w);
    repeat (2) begin
      @(negedge clk);
      #2;
      chk("t2_bubble_v", PW'(pkt_v_o), PW'(0));
    end
    send_flit(64'hB, w);
    chk("t2_pre_c_v", PW'(pkt_v_o), PW'(0));
    send_flit(64'hC, w);
    sb.push_back('{pkt: exp_pkt, len: 4'd3});
    chk("t2_v", PW'(pkt_v_o), PW'(1));
    chk("t2_pkt", pkt_o, exp_pkt);
    wait_drain();

    // 3: consumer stalls 5 cycles, then back-to-back header
    cons_mode = 1;
    send_pkt(mk_hdr(2), 0, w);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #2;
      chk("t3_ready_stall", PW'(link_o[0]), PW'(0));
      chk("t3_v_stall", PW'(pkt_v_o), PW'(1));
      chk("t3_pkt_stable", pkt_o, sb[0].pkt);
    end
    cons_mode = 0;
    send_pkt(mk_hdr(1), 0, w);
    chk("t3_b2b_wait", PW'(w), PW'(1));
    wait_drain();

    // 4: oversize len=9 is drained with a single err pulse on the last flit
    eb = err_cnt;
    vb = v_cnt;
    send_flit(mk_hdr(9), w);
    for (int k = 1; k <= 9; k++) begin
      send_flit({$urandom(), $urandom()}, w);
      chk("t4_ready", PW'(w), PW'(0));
      chk("t4_err_cnt", PW'(err_cnt - eb), PW'((k == 9) ? 1 : 0));
    end
    repeat (3) @(negedge clk);
    #2;
    chk("t4_err_once", PW'(err_cnt - eb), PW'(1));
    chk("t4_no_v", PW'(v_cnt - vb), PW'(0));
    chk("t4_idle_ready", PW'(link_o[0]), PW'(1));

    // 5: reset mid-packet, then a clean len=1 packet
    send_flit(mk_hdr(4), w);
    send_flit(64'h1111, w);
    send_flit(64'h2222, w);
    @(negedge clk);
    reset_n_i = 1'b0;
    repeat (2) begin
      #1;
      chk("t5_rst_ready", PW'(link_o[0]), PW'(0));
      chk("t5_rst_v", PW'(pkt_v_o), PW'(0));
      chk("t5_rst_link", PW'(link_o), PW'(0));
      @(negedge clk);
    end
    reset_n_i = 1'b1;
    #1;
    chk("t5_rel_ready", PW'(link_o[0]), PW'(1));
    send_pkt(mk_hdr(1), 0, w);
    wait_drain();

    // 6: random stream with bubbles and random consumer back-pressure
    cons_mode = 2;
    db = n_deliv;
    for (int p = 0; p < 40; p++) send_pkt(mk_hdr($urandom_range(0, ML)), 30, w);
    wait_drain();
    chk("t6_count", PW'(n_deliv - db), PW'(40));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
